ps2_kbd_cmd_ctrl: RTL

- Host-to-device command sequencer for the PS/2 keyboard port; shares the bidirectional PS/2 clock/data lines with the existing receive decoder.
- When the requested LED state (caps/num/scroll, driven from shift_lock etc.) differs from the last acknowledged state, it sends the two-byte "ED, led_byte" command.
- Handles bus inhibit, bit-serial transmit, the ACK bit, the FA/FE response, retries and timeouts, and masks command responses from the keyboard matrix path.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_sync.sv | 32 +++
 rtl/ps2_kbd_cmd_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: protocol bytes, command sequencer states and
// the helpers used to build a transmitted byte.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;
  localparam int         HZ_PER_MHZ     = 1000000;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    TX,
    RESP,
    RETRY
  } ps2_state_t;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic logic [7:0] led_byte(input logic [2:0] leds);
    return {5'b0, leds};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data lines, plus a
// one-cycle pulse on each falling edge of the synchronised clock.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_fe,
  output logic o_data
);

  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic       r_clk_d;

  // Lines idle high, so reset to 1 keeps a spurious edge from appearing after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta  <= 2'b11;
      r_sync  <= 2'b11;
      r_clk_d <= 1'b1;
    end else begin
      r_meta  <= {i_ps2_data, i_ps2_clk};
      r_sync  <= r_meta;
      r_clk_d <= r_sync[0];
    end
  end

  assign o_clk_fe = r_clk_d & ~r_sync[0];
  assign o_data   = r_sync[1];

endmodule

// File: rtl/ps2_kbd_cmd_ctrl.sv
// Host-to-keyboard "set LEDs" sequencer: sends ED followed by the LED byte
// whenever the requested LEDs differ from the last acknowledged state.
module ps2_kbd_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 32000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 20000,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [2:0] leds,
  input  logic       rx_strobe,
  input  logic [7:0] rx_code,
  output logic       rx_mask,
  output logic       busy,
  output logic       err
);

  localparam int INHIBIT_CYC = CLK_HZ / HZ_PER_MHZ * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / HZ_PER_MHZ * TIMEOUT_US;
  localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
  localparam int WDG_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic w_clk_fe;
  logic w_data_sync;

  ps2_line_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_ps2_clk  (ps2_clk_in),
    .i_ps2_data (ps2_data_in),
    .o_clk_fe   (w_clk_fe),
    .o_data     (w_data_sync)
  );

  ps2_state_t       r_state, w_state_next;
  logic [2:0]       r_snap, w_snap_next;
  logic [2:0]       r_leds_sent, w_leds_sent_next;
  logic             r_byte_idx, w_byte_idx_next;
  logic [RTY_W-1:0] r_retry, w_retry_next;
  logic [3:0]       r_bit_cnt, w_bit_cnt_next;
  logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_next;
  logic [WDG_W-1:0] r_wdog, w_wdog_next;
  logic             r_clk_oe, w_clk_oe_next;
  logic             r_data_oe, w_data_oe_next;
  logic             r_err, w_err_next;
  logic             r_mask_hold, w_mask_hold_next;
  logic [7:0]       w_tx_byte;

  assign w_tx_byte = r_byte_idx ? led_byte(r_snap) : PS2_CMD_SETLED;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_leds_sent <= '0;
      r_byte_idx  <= 1'b0;
      r_retry     <= '0;
      r_bit_cnt   <= '0;
      r_inh_cnt   <= '0;
      r_wdog      <= '0;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
      r_err       <= 1'b0;
      r_mask_hold <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_snap      <= w_snap_next;
      r_leds_sent <= w_leds_sent_next;
      r_byte_idx  <= w_byte_idx_next;
      r_retry     <= w_retry_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_inh_cnt   <= w_inh_cnt_next;
      r_wdog      <= w_wdog_next;
      r_clk_oe    <= w_clk_oe_next;
      r_data_oe   <= w_data_oe_next;
      r_err       <= w_err_next;
      r_mask_hold <= w_mask_hold_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_snap_next      = r_snap;
    w_leds_sent_next = r_leds_sent;
    w_byte_idx_next  = r_byte_idx;
    w_retry_next     = r_retry;
    w_bit_cnt_next   = r_bit_cnt;
    w_inh_cnt_next   = r_inh_cnt;
    w_wdog_next      = r_wdog;
    w_clk_oe_next    = r_clk_oe;
    w_data_oe_next   = r_data_oe;
    w_err_next       = r_err;

    if ((r_state == TX || r_state == RESP) && r_wdog != '0) begin
      w_wdog_next = r_wdog - WDG_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (leds != r_leds_sent) begin
          w_snap_next     = leds;
          w_byte_idx_next = 1'b0;
          w_retry_next    = '0;
          w_state_next    = INHIBIT;
          w_clk_oe_next   = 1'b1;
          w_data_oe_next  = 1'b0;
          w_inh_cnt_next  = INH_W'(INHIBIT_CYC - 1);
        end
      end

      INHIBIT: begin
        if (r_inh_cnt == '0) begin
          // Release the clock with data held low: that is the start bit.
          w_clk_oe_next  = 1'b0;
          w_data_oe_next = 1'b1;
          w_bit_cnt_next = '0;
          w_wdog_next    = WDG_W'(TIMEOUT_CYC);
          w_state_next   = TX;
        end else begin
          w_inh_cnt_next = r_inh_cnt - INH_W'(1);
        end
      end

      TX: begin
        if (r_wdog == '0) begin
          w_data_oe_next = 1'b0;
          w_clk_oe_next  = 1'b0;
          w_state_next   = RETRY;
        end else if (w_clk_fe) begin
          w_bit_cnt_next = r_bit_cnt + 4'd1;
          if (r_bit_cnt < 4'd8) begin
            w_data_oe_next = ~w_tx_byte[r_bit_cnt[2:0]];
          end else if (r_bit_cnt == 4'd8) begin
            w_data_oe_next = ~odd_parity(w_tx_byte);
          end else if (r_bit_cnt == 4'd9) begin
            w_data_oe_next = 1'b0;
          end else begin
            // Eleventh edge: the device pulls data low to acknowledge the frame.
            w_data_oe_next = 1'b0;
            w_state_next   = w_data_sync ? RETRY : RESP;
          end
        end
      end

      RESP: begin
        if (r_wdog == '0) begin
          w_data_oe_next = 1'b0;
          w_clk_oe_next  = 1'b0;
          w_state_next   = RETRY;
        end else if (rx_strobe) begin
          case (rx_code)
            PS2_ACK: begin
              if (!r_byte_idx) begin
                w_byte_idx_next = 1'b1;
                w_retry_next    = '0;
                w_state_next    = INHIBIT;
                w_clk_oe_next   = 1'b1;
                w_data_oe_next  = 1'b0;
                w_inh_cnt_next  = INH_W'(INHIBIT_CYC - 1);
              end else begin
                w_leds_sent_next = r_snap;
                w_err_next       = 1'b0;
                w_state_next     = IDLE;
              end
            end
            PS2_RESEND: w_state_next = RETRY;
            default:    w_state_next = RETRY;
          endcase
        end
      end

      RETRY: begin
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = 1'b0;
        if (r_retry < RTY_W'(MAX_RETRY)) begin
          w_retry_next   = r_retry + RTY_W'(1);
          w_state_next   = INHIBIT;
          w_clk_oe_next  = 1'b1;
          w_inh_cnt_next = INH_W'(INHIBIT_CYC - 1);
        end else begin
          // Record the LEDs as sent anyway so a dead keyboard is not hammered forever.
          w_err_next       = 1'b1;
          w_leds_sent_next = r_snap;
          w_state_next     = IDLE;
        end
      end

      default: begin
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = 1'b0;
        w_state_next   = IDLE;
      end
    endcase

    // The response strobe that ends a command lands in the same cycle we leave,
    // so the mask is stretched by one cycle to cover a registered decoder.
    w_mask_hold_next = (r_state != IDLE) && (w_state_next == IDLE);
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign busy        = (r_state != IDLE);
  assign rx_mask     = (r_state != IDLE) | r_mask_hold;
  assign err         = r_err;

endmodule
